// File: rtl/bp_pkg.sv
// Shared definitions for the branch pattern history table controller:
// 2-bit counter encoding, controller state type and the saturating update rule.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {INIT, RUN} state_t;

  // Taken moves toward ST, not-taken toward SNT, both saturating.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (cnt == ST) ? ST : cnt + 2'd1;
    end else begin
      res = (cnt == SNT) ? SNT : cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates ({idx, taken})
// until the single table write port can retire them.
module bp_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; entries need no reset since count gates their visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (power-of-2 depth); simultaneous push/pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_pht_ctrl.sv
// Pattern history table controller: combinational fetch lookup, queued
// EX-stage updates retired one per cycle, and a post-reset init sweep.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module bp_pht_ctrl
  import bp_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int IDX_W   = 6,
  parameter int Q_DEPTH = 4,
  parameter int GHR_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  lk_pc,
  output logic             lk_pred,
  output logic [IDX_W-1:0] lk_idx,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             init_done,
  output logic             busy
);

  localparam int ENTRIES = 2**IDX_W;
  localparam int QCW     = $clog2(Q_DEPTH) + 1;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] sweep_ptr;
  logic [1:0]       pht [ENTRIES];

  logic             push;
  logic             pop;
  logic             q_full;
  logic             q_empty;
  logic [QCW-1:0]   q_count;
  logic [IDX_W:0]   head;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [IDX_W-1:0] pc_idx;

  logic             unused_pc;
  assign unused_pc = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0]};

  assign pc_idx     = lk_pc[IDX_W+1:2];
  assign push       = upd_valid && upd_ready;
  assign pop        = (state == RUN) && !q_empty;
  assign head_idx   = head[IDX_W:1];
  assign head_taken = head[0];

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // Non-speculative global history: shifts in the outcome of each accepted update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (push) begin
      ghr <= {ghr[GHR_W-2:0], upd_taken};
    end
  end

  assign lk_idx = pc_idx ^ IDX_W'(ghr);
`else
  localparam int unused_ghr_w = GHR_W;
  assign lk_idx = pc_idx;
`endif

  bp_upd_fifo #(
    .DEPTH (Q_DEPTH),
    .W     (IDX_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({upd_idx, upd_taken}),
    .pop       (pop),
    .pop_data  (head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // State register and sweep pointer; reset restarts the init sweep from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      sweep_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT) begin
        sweep_ptr <= sweep_ptr + 1'b1;
      end
    end
  end

  // Next state and handshake/status outputs; the sweep ends after the last entry.
  always_comb begin
    state_next = state;
    upd_ready  = 1'b0;
    init_done  = 1'b0;
    busy       = 1'b1;
    lk_pred    = 1'b0;
    case (state)
      INIT: begin
        if (&sweep_ptr) begin
          state_next = RUN;
        end
      end
      RUN: begin
        upd_ready = !q_full;
        init_done = 1'b1;
        busy      = (q_count != '0);
        lk_pred   = pht[lk_idx][1];
      end
      default: state_next = INIT;
    endcase
  end

  // Single table write port: init sweep writes WNT, otherwise the queue head does its RMW.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        pht[sweep_ptr] <= WNT;
      end else if (pop) begin
        pht[head_idx] <= sat_update(pht[head_idx], head_taken);
      end
    end
  end

endmodule
